// File: rtl/muldiv_pkg.sv
// Shared constants for the HI/LO multiply/divide sequencer: source select,
// opfunc codes, FSM state encoding and default datapath width.
package muldiv_pkg;

  localparam int unsigned MD_WIDTH = 32;

  // Source select carried in opfunc[6]
  localparam logic SRC_OPCODE = 1'b0;
  localparam logic SRC_FUNC   = 1'b1;

  // Function field values for the HI/LO instructions
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;

  // Full 7-bit opfunc values as seen on in_opfunc
  localparam logic [6:0] OPF_MFHI  = {SRC_FUNC, FN_MFHI};
  localparam logic [6:0] OPF_MTHI  = {SRC_FUNC, FN_MTHI};
  localparam logic [6:0] OPF_MFLO  = {SRC_FUNC, FN_MFLO};
  localparam logic [6:0] OPF_MTLO  = {SRC_FUNC, FN_MTLO};
  localparam logic [6:0] OPF_MULT  = {SRC_FUNC, FN_MULT};
  localparam logic [6:0] OPF_MULTU = {SRC_FUNC, FN_MULTU};
  localparam logic [6:0] OPF_DIV   = {SRC_FUNC, FN_DIV};
  localparam logic [6:0] OPF_DIVU  = {SRC_FUNC, FN_DIVU};

  typedef enum logic [1:0] {
    MD_IDLE  = 2'd0,
    MD_MUL   = 2'd1,
    MD_DIV   = 2'd2,
    MD_FIXUP = 2'd3
  } md_state_e;

endpackage

// File: rtl/muldiv_iter_step.sv
// One iteration of the magnitude datapath: a shift-add multiply step or a
// restoring divide step. The divide quotient bit is returned separately; the
// low bit of acc_next is left 0 in divide mode for the controller to fill.
module muldiv_iter_step
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = MD_WIDTH
) (
  input  logic                 div_mode,
  input  logic [2*WIDTH-1:0]   acc,
  input  logic [WIDTH-1:0]     opnd,
  output logic [2*WIDTH-1:0]   acc_next,
  output logic                 q_bit
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   rem_top;
  logic [WIDTH-1:0] rem_new;

  // Multiply: add multiplicand when multiplier LSB set, shift right.
  // Divide: shift remainder left with next dividend bit, subtract if it fits.
  always_comb begin
    sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    rem_top  = acc[2*WIDTH-1:WIDTH-1];
    q_bit    = 1'b0;
    rem_new  = rem_top[WIDTH-1:0];
    acc_next = {sum, acc[WIDTH-1:1]};
    if (div_mode) begin
      q_bit    = (rem_top >= {1'b0, opnd});
      rem_new  = q_bit ? (rem_top[WIDTH-1:0] - opnd) : rem_top[WIDTH-1:0];
      acc_next = {rem_new, acc[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/muldiv_controller.sv
// EX-stage HI/LO multiply/divide sequencer: iterative MULT/MULTU/DIV/DIVU,
// MFHI/MFLO/MTHI/MTLO service, and pipeline stall while an op is in flight.
module muldiv_controller
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = MD_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [6:0]       in_opfunc,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             cancel,
  output logic             stall,
  output logic             busy,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  md_state_e          state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               busy_q, busy_d;
  logic               is_div_q, is_div_d;
  logic               neg_q, neg_d;
  logic               rneg_q, rneg_d;
  logic               dz_q, dz_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  logic is_mf_hi, is_mf_lo, is_mt_hi, is_mt_lo;
  logic is_mul_op, is_div_op, op_signed;
  logic hilo_op, accept;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [2*WIDTH-1:0] step_acc;
  logic               step_q;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quot, rem;

  muldiv_iter_step #(.WIDTH(WIDTH)) u_step (
    .div_mode (state_q == MD_DIV),
    .acc      (acc_q),
    .opnd     (opnd_q),
    .acc_next (step_acc),
    .q_bit    (step_q)
  );

  // Opfunc decode, acceptance and operand magnitudes
  always_comb begin
    is_mf_hi  = (in_opfunc == OPF_MFHI);
    is_mf_lo  = (in_opfunc == OPF_MFLO);
    is_mt_hi  = (in_opfunc == OPF_MTHI);
    is_mt_lo  = (in_opfunc == OPF_MTLO);
    is_mul_op = (in_opfunc == OPF_MULT) || (in_opfunc == OPF_MULTU);
    is_div_op = (in_opfunc == OPF_DIV)  || (in_opfunc == OPF_DIVU);
    op_signed = (in_opfunc == OPF_MULT) || (in_opfunc == OPF_DIV);
    hilo_op   = in_valid & (is_mf_hi | is_mf_lo | is_mt_hi | is_mt_lo |
                            is_mul_op | is_div_op);
    accept    = hilo_op & ~busy_q & ~cancel;
    a_mag     = (op_signed & in_a[WIDTH-1]) ? -in_a : in_a;
    b_mag     = (op_signed & in_b[WIDTH-1]) ? -in_b : in_b;
  end

  // State and datapath registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= MD_IDLE;
      count_q  <= '0;
      busy_q   <= 1'b0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      dz_q     <= 1'b0;
      opnd_q   <= '0;
      acc_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      busy_q   <= busy_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      dz_q     <= dz_d;
      opnd_q   <= opnd_d;
      acc_q    <= acc_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  // Next-state: iterate WIDTH steps, one fixup cycle, cancel returns to idle
  always_comb begin
    state_d = state_q;
    case (state_q)
      MD_IDLE: begin
        if (accept & is_mul_op)      state_d = MD_MUL;
        else if (accept & is_div_op) state_d = MD_DIV;
      end
      MD_MUL, MD_DIV: begin
        if (count_q == LAST_CNT) state_d = MD_FIXUP;
      end
      MD_FIXUP: state_d = MD_IDLE;
      default:  state_d = MD_IDLE;
    endcase
    if (cancel) state_d = MD_IDLE;
    busy_d = (state_d != MD_IDLE);
  end

  // Datapath: operand capture, iteration, sign fixup and HI/LO writes
  always_comb begin
    count_d  = count_q;
    is_div_d = is_div_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    dz_d     = dz_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    prod     = neg_q ? -acc_q : acc_q;
    quot     = (neg_q & ~dz_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem      = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    case (state_q)
      MD_IDLE: begin
        count_d = '0;
        if (accept & is_mul_op) begin
          opnd_d   = a_mag;
          acc_d    = {{WIDTH{1'b0}}, b_mag};
          neg_d    = op_signed & (in_a[WIDTH-1] ^ in_b[WIDTH-1]);
          rneg_d   = 1'b0;
          dz_d     = 1'b0;
          is_div_d = 1'b0;
        end else if (accept & is_div_op) begin
          opnd_d   = b_mag;
          acc_d    = {{WIDTH{1'b0}}, a_mag};
          neg_d    = op_signed & (in_a[WIDTH-1] ^ in_b[WIDTH-1]);
          rneg_d   = op_signed & in_a[WIDTH-1];
          dz_d     = (in_b == '0);
          is_div_d = 1'b1;
        end else if (accept & is_mt_hi) begin
          hi_d = in_a;
        end else if (accept & is_mt_lo) begin
          lo_d = in_a;
        end
      end
      MD_MUL, MD_DIV: begin
        acc_d   = {step_acc[2*WIDTH-1:1], (state_q == MD_DIV) ? step_q : step_acc[0]};
        count_d = count_q + CNT_W'(1);
      end
      MD_FIXUP: begin
        count_d = '0;
        if (!cancel) begin
          if (is_div_q) begin
            hi_d = rem;
            lo_d = quot;
          end else begin
            {hi_d, lo_d} = prod;
          end
        end
      end
      default: count_d = '0;
    endcase
    if (cancel) count_d = '0;
  end

  // Pipeline-facing outputs
  always_comb begin
    stall  = hilo_op & busy_q & ~cancel;
    result = '0;
    if (accept & is_mf_hi)      result = hi_q;
    else if (accept & is_mf_lo) result = lo_q;
    busy = busy_q;
    hi   = hi_q;
    lo   = lo_q;
  end

endmodule

// File: tb/tb_muldiv_controller.sv
// Self-checking bench for muldiv_controller: directed corner cases plus
// randomized HI/LO ops against a plain-arithmetic reference model.
module tb_muldiv_controller;

  localparam logic [6:0] OP_MFHI  = 7'h50;
  localparam logic [6:0] OP_MTHI  = 7'h51;
  localparam logic [6:0] OP_MFLO  = 7'h52;
  localparam logic [6:0] OP_MTLO  = 7'h53;
  localparam logic [6:0] OP_MULT  = 7'h58;
  localparam logic [6:0] OP_MULTU = 7'h59;
  localparam logic [6:0] OP_DIV   = 7'h5A;
  localparam logic [6:0] OP_DIVU  = 7'h5B;
  localparam logic [6:0] OP_ADD   = 7'h60;

  logic        clock, reset, in_valid, cancel;
  logic [6:0]  in_opfunc;
  logic [31:0] in_a, in_b;
  logic        stall, busy;
  logic [31:0] result, hi, lo;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] hi_m, lo_m;

  muldiv_controller dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_opfunc (in_opfunc),
    .in_a      (in_a),
    .in_b      (in_b),
    .cancel    (cancel),
    .stall     (stall),
    .busy      (busy),
    .result    (result),
    .hi        (hi),
    .lo        (lo)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic cyc();
    @(posedge clock);
    #2;
  endtask

  // Reference architectural effect of one accepted op on HI/LO
  task automatic model_op(input logic [6:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      OP_MULT:  begin p = 64'(sa * sb); hi_m = p[63:32]; lo_m = p[31:0]; end
      OP_MULTU: begin p = {32'd0, a} * {32'd0, b}; hi_m = p[63:32]; lo_m = p[31:0]; end
      OP_DIV: begin
        if (b == 32'd0) begin lo_m = 32'hFFFF_FFFF; hi_m = a; end
        else begin q = sa / sb; r = sa % sb; lo_m = q[31:0]; hi_m = r[31:0]; end
      end
      OP_DIVU: begin
        if (b == 32'd0) begin lo_m = 32'hFFFF_FFFF; hi_m = a; end
        else begin lo_m = a / b; hi_m = a % b; end
      end
      OP_MTHI: hi_m = a;
      OP_MTLO: lo_m = a;
      default: ;
    endcase
  endtask

  function automatic logic [31:0] rand_word();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      default: return 32'($urandom);
    endcase
  endfunction

  // Issue op, then a dependent MF read the next cycle; check stall length and HI/LO
  task automatic run_op(input logic [6:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [6:0] rd);
    int n;
    bit is_long;
    logic [31:0] hi_before;
    is_long = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
    in_valid = 1'b1; in_opfunc = op; in_a = a; in_b = b;
    #1;
    check("issue_stall", 64'(stall), 64'd0);
    hi_before = hi_m;
    model_op(op, a, b);
    cyc();
    in_opfunc = rd; in_a = $urandom; in_b = $urandom;
    #1;
    n = 0;
    while (stall && n < 60) begin
      n++;
      if (n == 16) check("hi_hold_midop", 64'(hi), 64'(hi_before));
      cyc();
      #1;
    end
    check("stall_cycles", 64'(n), is_long ? 64'd33 : 64'd0);
    check("busy_after", 64'(busy), 64'd0);
    check("hi", 64'(hi), 64'(hi_m));
    check("lo", 64'(lo), 64'(lo_m));
    check("mf_result", 64'(result), (rd == OP_MFHI) ? 64'(hi_m) : 64'(lo_m));
    cyc();
    in_valid = 1'b0;
  endtask

  initial begin
    int n;
    logic [6:0] ops [8];
    ops = '{OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO, OP_MFHI, OP_MFLO};
    reset = 1'b1; in_valid = 1'b0; in_opfunc = '0; in_a = '0; in_b = '0; cancel = 1'b0;
    hi_m = '0; lo_m = '0;
    cyc(); cyc();
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    check("rst_stall", 64'(stall), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    reset = 1'b0;
    cyc();

    // Directed corner cases
    run_op(OP_MULT, 32'hFFFF_FFFE, 32'd3, OP_MFLO);
    check("mult_neg_lo", 64'(lo), 64'hFFFF_FFFA);
    check("mult_neg_hi", 64'(hi), 64'hFFFF_FFFF);
    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, OP_MFHI);
    check("multu_max_hi", 64'(hi), 64'hFFFF_FFFE);
    check("multu_max_lo", 64'(lo), 64'h0000_0001);
    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, OP_MFLO);
    check("div_neg_lo", 64'(lo), 64'hFFFF_FFFD);
    check("div_neg_hi", 64'(hi), 64'hFFFF_FFFF);
    run_op(OP_DIVU, 32'd7, 32'd0, OP_MFHI);
    check("divu_dz_lo", 64'(lo), 64'hFFFF_FFFF);
    check("divu_dz_hi", 64'(hi), 64'd7);
    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, OP_MFLO);
    check("div_ovf_lo", 64'(lo), 64'h8000_0000);
    check("div_ovf_hi", 64'(hi), 64'd0);
    run_op(OP_MTHI, 32'h1234, 32'd0, OP_MFHI);
    check("mthi_hi", 64'(hi), 64'h1234);

    // Cancel mid-DIVU together with an MTLO
    in_valid = 1'b1; in_opfunc = OP_DIVU; in_a = 32'd100; in_b = 32'd7;
    cyc();
    in_valid = 1'b0;
    for (int i = 0; i < 9; i++) cyc();
    in_valid = 1'b1; in_opfunc = OP_MTLO; in_a = 32'hDEAD_BEEF; cancel = 1'b1;
    #1;
    check("cancel_stall", 64'(stall), 64'd0);
    cyc();
    in_valid = 1'b0; cancel = 1'b0;
    #1;
    check("cancel_busy", 64'(busy), 64'd0);
    check("cancel_hi", 64'(hi), 64'(hi_m));
    check("cancel_lo", 64'(lo), 64'(lo_m));
    cyc();
    check("cancel_lo_later", 64'(lo), 64'(lo_m));

    // Reset mid-MULT
    in_valid = 1'b1; in_opfunc = OP_MULT; in_a = 32'd12345; in_b = 32'd678;
    cyc();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    hi_m = '0; lo_m = '0;
    #1;
    check("rstmid_busy", 64'(busy), 64'd0);
    check("rstmid_hi", 64'(hi), 64'd0);
    check("rstmid_lo", 64'(lo), 64'd0);

    // Non-HI/LO opfunc never stalls, even while busy
    in_valid = 1'b1; in_opfunc = OP_MULT; in_a = 32'hFFFF_FFF0; in_b = 32'h0001_0001;
    model_op(OP_MULT, in_a, in_b);
    cyc();
    in_opfunc = OP_ADD;
    #1;
    check("add_stall", 64'(stall), 64'd0);
    check("add_result", 64'(result), 64'd0);
    in_valid = 1'b0;
    n = 0;
    while (busy && n < 60) begin n++; cyc(); #1; end
    check("add_wait_done", 64'(busy), 64'd0);
    check("add_mult_hi", 64'(hi), 64'(hi_m));
    check("add_mult_lo", 64'(lo), 64'(lo_m));
    cyc();

    // Randomized ops against the reference model
    for (int t = 0; t < 60; t++) begin
      run_op(ops[$urandom_range(0, 7)], rand_word(), rand_word(),
             $urandom_range(0, 1) ? OP_MFHI : OP_MFLO);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
